// File: rtl/pp_accumulate.sv
// Sequential reduction of 32 pre-shifted 64-bit partial products into one product.
// Optional macro PP_ZERO_SKIP_EN ends accumulation early once the remaining partial products are all zero.
module pp_accumulate #(
  parameter int PP_PER_CYCLE = 4,
  parameter int N_PP         = 32,
  parameter int W            = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_PP*W-1:0]   pp_bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        product,
  output logic                busy
);

  localparam int IDX_W = $clog2(N_PP) + 1;
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(PP_PER_CYCLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PP);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              r_state;
  logic [N_PP-1:0][W-1:0]  r_pp_q;
  logic [W-1:0]            r_acc;
  logic [W-1:0]            r_product;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_out_valid;

  logic [W-1:0]            w_group_sum;
  logic [W-1:0]            w_acc_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic                    w_finish;
  logic                    w_accept;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_idx_next = r_idx + IDX_STEP;
  assign w_acc_next = r_acc + w_group_sum;

  // The captured bundle shifts down each ACCUM cycle, so the current group always sits in the low slots.
  always_comb begin
    w_group_sum = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      w_group_sum = w_group_sum + r_pp_q[j];
    end
  end

`ifdef PP_ZERO_SKIP_EN
  logic w_rest_zero;
  assign w_rest_zero = ((r_pp_q >> (PP_PER_CYCLE * W)) == '0);
  assign w_finish    = (w_idx_next == IDX_LAST) || w_rest_zero;
`else
  assign w_finish    = (w_idx_next == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pp_q <= pp_bus;
    end else if (r_state == S_ACCUM) begin
      r_pp_q <= r_pp_q >> (PP_PER_CYCLE * W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_idx   <= '0;
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_next;
          r_idx <= w_idx_next;
          if (w_finish) begin
            r_state     <= S_DONE;
            r_product   <= w_acc_next;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Returning to IDLE first guarantees no bundle is accepted on the output handshake edge.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_pp_accumulate.sv
// Directed self-checking bench for pp_accumulate at PP_PER_CYCLE 4, plus 1 and 32 instances.
// Expected latencies follow the PP_ZERO_SKIP_EN setting of the build.
module tb_pp_accumulate;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, out_ready;
  logic [2047:0] pp_bus;
  logic          in_ready, out_valid, busy;
  logic [63:0]   product;

  logic          in_valid_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
  logic [63:0]   product_a;
  logic          in_valid_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
  logic [63:0]   product_b;

  int checks = 0;
  int errors = 0;

`ifdef PP_ZERO_SKIP_EN
  localparam int LAT_SPARSE = 1;
`else
  localparam int LAT_SPARSE = 8;
`endif

  always #5 clk = ~clk;

  pp_accumulate #(.PP_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pp_bus(pp_bus),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );

  pp_accumulate #(.PP_PER_CYCLE(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .pp_bus(pp_bus),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .product(product_a), .busy(busy_a)
  );

  pp_accumulate #(.PP_PER_CYCLE(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .pp_bus(pp_bus),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .product(product_b), .busy(busy_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Shift-and-add partial products of a*b: pp_i = b[i] ? a<<i : 0.
  function automatic logic [2047:0] ppOf(input logic [31:0] a, input logic [31:0] b);
    logic [2047:0] bundle;
    bundle = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) bundle[64*i +: 64] = {32'h0, a} << i;
    end
    return bundle;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input string tag, input logic [2047:0] bundle);
    checkOutput({tag, "_in_ready_before"}, {63'h0, in_ready}, 64'd1);
    pp_bus   = bundle;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_busy_after_accept"}, {63'h0, busy}, 64'd1);
  endtask

  task automatic waitOutValid(output int edges, output int readyHighs);
    edges      = 0;
    readyHighs = 0;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
      if (in_ready !== 1'b0) readyHighs++;
    end
  endtask

  initial begin
    logic [2047:0] bundle;
    int edges, readyHighs, ea, eb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pp_bus = '0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", {63'h0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'h0, out_valid}, 64'd0);
    checkOutput("reset_product", product, 64'd0);
    checkOutput("reset_busy", {63'h0, busy}, 64'd0);

    // Test 1: sparse bundle, pp0=3, pp2=12
    bundle = '0;
    bundle[63:0]    = 64'd3;
    bundle[191:128] = 64'd12;
    applyStimulus("t1", bundle);
    waitOutValid(edges, readyHighs);
    checkOutput("t1_latency", 64'(edges), 64'(LAT_SPARSE));
    checkOutput("t1_product", product, 64'h0F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t1_out_valid_after_hs", {63'h0, out_valid}, 64'd0);
    checkOutput("t1_in_ready_after_hs", {63'h0, in_ready}, 64'd1);
    checkOutput("t1_product_kept", product, 64'h0F);

    // Test 2: 0xFFFFFFFF squared
    applyStimulus("t2", ppOf(32'hFFFF_FFFF, 32'hFFFF_FFFF));
    waitOutValid(edges, readyHighs);
    checkOutput("t2_latency", 64'(edges), 64'd8);
    checkOutput("t2_in_ready_high_count", 64'(readyHighs), 64'd0);
    checkOutput("t2_product", product, 64'hFFFF_FFFE_0000_0001);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Test 3: all-ones partial products wrap to -32
    bundle = '1;
    applyStimulus("t3", bundle);
    waitOutValid(edges, readyHighs);
    checkOutput("t3_latency", 64'(edges), 64'd8);
    checkOutput("t3_product", product, 64'hFFFF_FFFF_FFFF_FFE0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    pp_bus = '1;
    in_valid_a = 1'b1; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    ea = -1; eb = -1;
    for (int n = 1; n <= 100 && (ea < 0 || eb < 0); n++) begin
      @(negedge clk);
      if (out_valid_a === 1'b1 && ea < 0) ea = n;
      if (out_valid_b === 1'b1 && eb < 0) eb = n;
    end
    checkOutput("t3_ppc1_latency", 64'(ea), 64'd32);
    checkOutput("t3_ppc32_latency", 64'(eb), 64'd1);
    checkOutput("t3_ppc1_product", product_a, 64'hFFFF_FFFF_FFFF_FFE0);
    checkOutput("t3_ppc32_product", product_b, 64'hFFFF_FFFF_FFFF_FFE0);
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    checkOutput("t3_ppc1_in_ready", {63'h0, in_ready_a}, 64'd1);
    checkOutput("t3_ppc32_in_ready", {63'h0, in_ready_b}, 64'd1);

    // Test 4: stall the output for 5 cycles while offering another bundle
    applyStimulus("t4", ppOf(32'd5, 32'd1));
    waitOutValid(edges, readyHighs);
    pp_bus   = ppOf(32'd9, 32'd1);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("t4_stall_out_valid", {63'h0, out_valid}, 64'd1);
      checkOutput("t4_stall_product", product, 64'd5);
      checkOutput("t4_stall_in_ready", {63'h0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("t4_idle_in_ready", {63'h0, in_ready}, 64'd1);
    checkOutput("t4_idle_busy", {63'h0, busy}, 64'd0);
    checkOutput("t4_idle_out_valid", {63'h0, out_valid}, 64'd0);

    // Test 5: reset in the third ACCUM cycle, then a fresh bundle
    bundle = '1;
    applyStimulus("t5", bundle);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_rst_in_ready", {63'h0, in_ready}, 64'd1);
    checkOutput("t5_rst_out_valid", {63'h0, out_valid}, 64'd0);
    checkOutput("t5_rst_product", product, 64'd0);
    checkOutput("t5_rst_busy", {63'h0, busy}, 64'd0);
    bundle = '0;
    bundle[63:0] = 64'd7;
    applyStimulus("t5b", bundle);
    waitOutValid(edges, readyHighs);
    checkOutput("t5_latency", 64'(edges), 64'(LAT_SPARSE));
    checkOutput("t5_product", product, 64'd7);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Test 6: back-to-back with out_ready held high
    out_ready = 1'b1;
    applyStimulus("t6a", ppOf(32'd5, 32'd6));
    waitOutValid(edges, readyHighs);
    checkOutput("t6_first_out_valid", {63'h0, out_valid}, 64'd1);
    checkOutput("t6_first_product", product, 64'd30);
    pp_bus   = ppOf(32'd100, 32'd200);
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t6_no_same_cycle_accept", {63'h0, busy}, 64'd0);
    checkOutput("t6_hs_out_valid", {63'h0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("t6_second_accept", {63'h0, busy}, 64'd1);
    waitOutValid(edges, readyHighs);
    checkOutput("t6_second_product", product, 64'd20000);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("t6_second_hs", {63'h0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
